keypad_time_loader: RTL and testbench
=====================================

# keypad_time_loader

Upstream front end of the cook-time countdown chain. It collects BCD keypad digits into a three-digit M:S:S entry register and validates the seconds-tens digit. On start it issues the single-cycle active-low parallel-load pulse and preset data that the minutes, seconds-tens (mod-6) and seconds-ones counters consume. While cooking it holds the counter enable and returns to idle when the chain reports zero or the user cancels.

## Interface
Parameters:
- DIGITS, 3: number of entry digits (minutes, seconds-tens, seconds-ones); fixed at 3 in this release.

Ports:
- clock  in  1  system clock, rising-edge.
- clrn  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle strobe; key_digit is valid.
- key_digit  in  4  BCD digit from keypad encoder.
- start  in  1  one-cycle start request.
- cancel  in  1  one-cycle cancel/clear request.
- timer_zero  in  1  high when the downstream counter chain reads 0:00.
- min_data  out  4  preset for the minutes counter.
- sec_tens_data  out  4  preset for the mod-6 seconds-tens counter.
- sec_ones_data  out  4  preset for the seconds-ones counter.
- loadn  out  1  active-low parallel-load pulse to all three counters.
- cnt_en  out  1  count enable to the counter chain.
- digit_count  out  2  number of digits entered, 0..3.
- entry_error  out  1  one-cycle error pulse.

## Operation
- Reset values: state IDLE, all data outputs 4'd0, loadn=1, cnt_en=0, digit_count=0, entry_error=0.
- IDLE: no digits are held.
  - A valid key (key_digit ≤ 9) → ENTRY.
  - start → ignored.
- ENTRY: each valid key shifts left: ones→tens, tens→min, and the new digit enters ones.
  - The previous min digit is discarded.
  - digit_count increments and saturates at 3.
- Key with key_digit > 9 (any state except RUN): digit is dropped, registers are unchanged, entry_error pulses.
- start in ENTRY:
  - sec_tens_data ≤ 5 → LOAD.
  - sec_tens_data > 5 → see Configuration.
- LOAD: lasts exactly one cycle with loadn=0. The data outputs are stable during the pulse and stay stable afterwards. Next state is RUN.
- RUN: cnt_en=1.
  - key_valid and start → ignored.
  - timer_zero=1 or cancel → IDLE, with digits, digit_count and cnt_en cleared.
- cancel in ENTRY → IDLE, cleared. cancel in LOAD → IDLE; the load pulse still completes that cycle.
- Priority within one cycle: cancel > start > key_valid. A key arriving with start is dropped.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Key sampled at edge N → updated data and digit_count are visible after edge N.
- start sampled at edge N → loadn=0 from edge N+1 to edge N+2. cnt_en=1 from edge N+2.
- timer_zero sampled at edge N in RUN → cnt_en=0 and outputs cleared after edge N.
- timer_zero is ignored outside RUN. It is also ignored at the first RUN edge, because the counters have just loaded.
- clrn asserted at any time (including mid-LOAD or mid-RUN) immediately forces the reset values. loadn returns high asynchronously.
- entry_error is high for exactly one cycle per offending event.

## Configuration
- SEC_TENS_CLAMP_EN defined: start with sec_tens_data > 5 clamps sec_tens_data to 5 (sec_ones_data unchanged), proceeds to LOAD, and does not raise entry_error.
- SEC_TENS_CLAMP_EN undefined: start with sec_tens_data > 5 pulses entry_error, remains in ENTRY, and leaves all digits unchanged.

## Test plan
- Reset, then keys 1,3,0 and start → data 1/3/0, loadn low for exactly one cycle one edge after start, cnt_en high the next edge.
- Keys 4,5,6,7 → min=5, tens=6, ones=7, digit_count=3. Then start → without macro, entry_error pulse, no loadn, state stays ENTRY. With SEC_TENS_CLAMP_EN, tens=5 and a load occurs.
- key_digit=4'hB in ENTRY → entry_error one cycle, digits and digit_count unchanged.
- In RUN, raise timer_zero → cnt_en low and all data 0 after one edge. Keys pressed during RUN beforehand have no effect.
- start and cancel in the same cycle in ENTRY → IDLE with cleared data, loadn stays high. start and key_valid in the same cycle → load uses the prior digits.
- Assert clrn during the LOAD cycle → loadn goes high immediately, all outputs are at reset values, state is IDLE.

Source files
------------

// File: rtl/keypad_time_loader.sv
// Keypad front end for the cook-time counter chain: collects M:S:S digits, issues the preset load, then gates counting.
// Optional build macro SEC_TENS_CLAMP_EN: clamp an out-of-range seconds-tens digit to 5 on start instead of rejecting it.
module keypad_time_loader #(
  parameter int DIGITS = 3
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_zero,
  output logic [3:0] min_data,
  output logic [3:0] sec_tens_data,
  output logic [3:0] sec_ones_data,
  output logic       loadn,
  output logic       cnt_en,
  output logic [1:0] digit_count,
  output logic       entry_error
);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;

  localparam logic [1:0] MAX_CNT = 2'(DIGITS);

  state_t state;
  logic   first_run;
  logic   key_ok;
  logic   key_only;

  assign key_ok   = (key_digit <= 4'd9);
  // A key is only considered when neither higher-priority request is present.
  assign key_only = key_valid && !cancel && !start;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state         <= IDLE;
      first_run     <= 1'b0;
      min_data      <= 4'd0;
      sec_tens_data <= 4'd0;
      sec_ones_data <= 4'd0;
      loadn         <= 1'b1;
      cnt_en        <= 1'b0;
      digit_count   <= 2'd0;
      entry_error   <= 1'b0;
    end else begin
      entry_error <= 1'b0;
      loadn       <= 1'b1;
      case (state)
        IDLE: begin
          cnt_en <= 1'b0;
          if (key_only) begin
            if (key_ok) begin
              min_data      <= sec_tens_data;
              sec_tens_data <= sec_ones_data;
              sec_ones_data <= key_digit;
              digit_count   <= 2'd1;
              state         <= ENTRY;
            end else begin
              entry_error <= 1'b1;
            end
          end
        end

        ENTRY: begin
          if (cancel) begin
            min_data      <= 4'd0;
            sec_tens_data <= 4'd0;
            sec_ones_data <= 4'd0;
            digit_count   <= 2'd0;
            state         <= IDLE;
          end else if (start) begin
            if (sec_tens_data <= 4'd5) begin
              state <= LOAD;
            end else begin
`ifdef SEC_TENS_CLAMP_EN
              sec_tens_data <= 4'd5;
              state         <= LOAD;
`else
              entry_error <= 1'b1;
`endif
            end
          end else if (key_valid) begin
            if (key_ok) begin
              min_data      <= sec_tens_data;
              sec_tens_data <= sec_ones_data;
              sec_ones_data <= key_digit;
              if (digit_count != MAX_CNT)
                digit_count <= digit_count + 2'd1;
            end else begin
              entry_error <= 1'b1;
            end
          end
        end

        // Output pulse is registered here, so loadn is low for the cycle after LOAD.
        LOAD: begin
          loadn <= 1'b0;
          if (cancel) begin
            min_data      <= 4'd0;
            sec_tens_data <= 4'd0;
            sec_ones_data <= 4'd0;
            digit_count   <= 2'd0;
            state         <= IDLE;
          end else begin
            first_run <= 1'b1;
            state     <= RUN;
            if (key_only && !key_ok)
              entry_error <= 1'b1;
          end
        end

        RUN: begin
          first_run <= 1'b0;
          // timer_zero is stale on the first RUN edge: the counters are loading then.
          if (cancel || (timer_zero && !first_run)) begin
            min_data      <= 4'd0;
            sec_tens_data <= 4'd0;
            sec_ones_data <= 4'd0;
            digit_count   <= 2'd0;
            cnt_en        <= 1'b0;
            state         <= IDLE;
          end else begin
            cnt_en <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_time_loader.sv
// Directed bench for keypad_time_loader; expectations hand-computed, clamp branch selected by SEC_TENS_CLAMP_EN.
module tb_keypad_time_loader;

  logic       clock = 1'b0;
  logic       clrn;
  logic       key_valid, start, cancel, timer_zero;
  logic [3:0] key_digit;
  logic [3:0] min_data, sec_tens_data, sec_ones_data;
  logic       loadn, cnt_en, entry_error;
  logic [1:0] digit_count;

  int checks = 0;
  int errors = 0;

  keypad_time_loader #(.DIGITS(3)) dut (
    .clock(clock), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .cancel(cancel), .timer_zero(timer_zero),
    .min_data(min_data), .sec_tens_data(sec_tens_data), .sec_ones_data(sec_ones_data),
    .loadn(loadn), .cnt_en(cnt_en), .digit_count(digit_count), .entry_error(entry_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
    key_valid = 1'b0;
  endtask

  task automatic data3(input string tag, input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
    chk({tag, "_min"}, 8'(min_data), 8'(m));
    chk({tag, "_tens"}, 8'(sec_tens_data), 8'(t));
    chk({tag, "_ones"}, 8'(sec_ones_data), 8'(o));
  endtask

  initial begin
    clrn = 1'b0; key_valid = 1'b0; key_digit = 4'd0;
    start = 1'b0; cancel = 1'b0; timer_zero = 1'b0;
    #12;
    data3("rst", 4'd0, 4'd0, 4'd0);
    chk("rst_loadn", 8'(loadn), 8'd1);
    chk("rst_cnt_en", 8'(cnt_en), 8'd0);
    chk("rst_count", 8'(digit_count), 8'd0);
    chk("rst_err", 8'(entry_error), 8'd0);
    step();
    clrn = 1'b1;

    // Keys 1,3,0 then start: load 1:30
    key(4'd1);
    chk("k1_count", 8'(digit_count), 8'd1);
    chk("k1_ones", 8'(sec_ones_data), 8'd1);
    key(4'd3);
    key(4'd0);
    data3("k130", 4'd1, 4'd3, 4'd0);
    chk("k130_count", 8'(digit_count), 8'd3);
    start = 1'b1; step(); start = 1'b0;
    chk("st_n_loadn", 8'(loadn), 8'd1);
    chk("st_n_cnt_en", 8'(cnt_en), 8'd0);
    timer_zero = 1'b1;
    step();
    chk("st_n1_loadn", 8'(loadn), 8'd0);
    chk("st_n1_cnt_en", 8'(cnt_en), 8'd0);
    data3("st_n1", 4'd1, 4'd3, 4'd0);
    step();
    timer_zero = 1'b0;
    chk("st_n2_loadn", 8'(loadn), 8'd1);
    chk("st_n2_cnt_en_tz_ignored", 8'(cnt_en), 8'd1);

    // Inputs ignored in RUN
    key(4'd9);
    data3("run_key", 4'd1, 4'd3, 4'd0);
    key(4'hB);
    chk("run_badkey_err", 8'(entry_error), 8'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("run_start_loadn", 8'(loadn), 8'd1);
    chk("run_cnt_en", 8'(cnt_en), 8'd1);
    timer_zero = 1'b1; step(); timer_zero = 1'b0;
    chk("tz_cnt_en", 8'(cnt_en), 8'd0);
    data3("tz", 4'd0, 4'd0, 4'd0);
    chk("tz_count", 8'(digit_count), 8'd0);

    // Shift with discard, saturating count, bad key
    key(4'd4); key(4'd5); key(4'd6); key(4'd7);
    data3("k4567", 4'd5, 4'd6, 4'd7);
    chk("k4567_count", 8'(digit_count), 8'd3);
    key(4'hB);
    chk("bad_err", 8'(entry_error), 8'd1);
    data3("bad", 4'd5, 4'd6, 4'd7);
    chk("bad_count", 8'(digit_count), 8'd3);
    step();
    chk("bad_err_clr", 8'(entry_error), 8'd0);

    start = 1'b1; step(); start = 1'b0;
`ifdef SEC_TENS_CLAMP_EN
    data3("clamp", 4'd5, 4'd5, 4'd7);
    chk("clamp_err", 8'(entry_error), 8'd0);
    step();
    chk("clamp_loadn", 8'(loadn), 8'd0);
    step();
    chk("clamp_cnt_en", 8'(cnt_en), 8'd1);
    cancel = 1'b1; step(); cancel = 1'b0;
    chk("clamp_cancel_cnt_en", 8'(cnt_en), 8'd0);
`else
    chk("tens6_err", 8'(entry_error), 8'd1);
    chk("tens6_loadn", 8'(loadn), 8'd1);
    data3("tens6", 4'd5, 4'd6, 4'd7);
    step();
    chk("tens6_loadn2", 8'(loadn), 8'd1);
    chk("tens6_err_clr", 8'(entry_error), 8'd0);
    key(4'd2);
    data3("tens6_entry", 4'd6, 4'd7, 4'd2);
    cancel = 1'b1; step(); cancel = 1'b0;
`endif
    data3("cancel", 4'd0, 4'd0, 4'd0);
    chk("cancel_count", 8'(digit_count), 8'd0);

    // start and cancel together in ENTRY
    key(4'd2);
    start = 1'b1; cancel = 1'b1; step(); start = 1'b0; cancel = 1'b0;
    chk("sc_count", 8'(digit_count), 8'd0);
    chk("sc_ones", 8'(sec_ones_data), 8'd0);
    chk("sc_loadn", 8'(loadn), 8'd1);
    step();
    chk("sc_loadn2", 8'(loadn), 8'd1);

    // start and key together: key dropped
    key(4'd1); key(4'd2);
    start = 1'b1; key_valid = 1'b1; key_digit = 4'd8;
    step();
    start = 1'b0; key_valid = 1'b0;
    data3("sk", 4'd0, 4'd1, 4'd2);
    chk("sk_count", 8'(digit_count), 8'd2);
    step();
    chk("sk_loadn", 8'(loadn), 8'd0);
    data3("sk_load", 4'd0, 4'd1, 4'd2);

    // Reset during the load pulse
    clrn = 1'b0;
    #1;
    chk("mid_rst_loadn", 8'(loadn), 8'd1);
    chk("mid_rst_cnt_en", 8'(cnt_en), 8'd0);
    data3("mid_rst", 4'd0, 4'd0, 4'd0);
    chk("mid_rst_count", 8'(digit_count), 8'd0);
    step();
    chk("mid_rst_loadn_held", 8'(loadn), 8'd1);
    clrn = 1'b1;
    key(4'd5);
    chk("post_rst_count", 8'(digit_count), 8'd1);
    chk("post_rst_ones", 8'(sec_ones_data), 8'd5);
    step();
    chk("post_rst_loadn", 8'(loadn), 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
